// File: rtl/rob_multi_wb.sv
// Reorder buffer with in-order commit, multiple writeback channels, operand bypass,
// store-commit handshake and full flush on taken branches / JALR.
module rob_multi_wb #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_WB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [4:0]               alloc_op,
  input  logic [4:0]               alloc_rd,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic [XLEN-1:0]          alloc_imm,
  output logic [IDX_W-1:0]         alloc_tag,
  input  logic [IDX_W-1:0]         src1_tag,
  input  logic [IDX_W-1:0]         src2_tag,
  output logic                     src1_ready,
  output logic                     src2_ready,
  output logic [XLEN-1:0]          src1_value,
  output logic [XLEN-1:0]          src2_value,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]  wb_tag,
  input  logic [NUM_WB*XLEN-1:0]   wb_value,
  output logic                     commit_valid,
  output logic [4:0]               commit_rd,
  output logic [XLEN-1:0]          commit_value,
  output logic [IDX_W-1:0]         commit_tag,
  output logic                     st_req,
  input  logic                     st_ack,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [IDX_W:0]           count
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [IDX_W:0] DepthCnt = {1'b1, {IDX_W{1'b0}}};

  // JALR has no encoding of its own in the opcode list; 10001 sits next to JAL.
  localparam logic [4:0] OpBeq  = 5'b01010;
  localparam logic [4:0] OpBge  = 5'b01011;
  localparam logic [4:0] OpBne  = 5'b01100;
  localparam logic [4:0] OpBgeu = 5'b01101;
  localparam logic [4:0] OpLui  = 5'b01110;
  localparam logic [4:0] OpAuipc = 5'b01111;
  localparam logic [4:0] OpJal  = 5'b10000;
  localparam logic [4:0] OpJalr = 5'b10001;
  localparam logic [4:0] OpStLo = 5'b10111;
  localparam logic [4:0] OpStHi = 5'b11001;
  localparam logic [4:0] OpBlt  = 5'b11010;
  localparam logic [4:0] OpBltu = 5'b11011;
  localparam logic [4:0] OpJalC = 5'b11100;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  function automatic logic is_store(input logic [4:0] op);
    return (op >= OpStLo) && (op <= OpStHi);
  endfunction

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OpBeq) || (op == OpBge) || (op == OpBne) || (op == OpBgeu) ||
           (op == OpBlt) || (op == OpBltu);
  endfunction

  function automatic logic ready_at_alloc(input logic [4:0] op);
    return (op == OpLui) || (op == OpAuipc) || (op == OpJal) || (op == OpJalC);
  endfunction

  idx_t            head_q, head_d, tail_q, tail_d;
  cnt_t            count_q, count_d;
  logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d;
  logic [4:0]      op_q    [DEPTH];
  logic [4:0]      rd_q    [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] imm_q   [DEPTH];
  logic [XLEN-1:0] value_q [DEPTH];
  logic [XLEN-1:0] value_d [DEPTH];

  logic            commit_valid_q, redirect_valid_q;
  logic [4:0]      commit_rd_q, commit_rd_d;
  logic [XLEN-1:0] commit_value_q, commit_value_d;
  idx_t            commit_tag_q;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  idx_t            wb_idx [NUM_WB];
  logic [XLEN-1:0] wb_val [NUM_WB];

  for (genvar k = 0; k < NUM_WB; k++) begin : g_wb_unpack
    assign wb_idx[k] = wb_tag[k*IDX_W +: IDX_W];
    assign wb_val[k] = wb_value[k*XLEN +: XLEN];
  end

  logic [4:0]      head_op;
  logic [XLEN-1:0] head_pc, head_imm, head_value;
  logic            head_store, head_branch, head_taken, head_ok, flush_now, alloc_fire;

  always_comb begin
    head_op     = op_q[head_q];
    head_pc     = pc_q[head_q];
    head_imm    = imm_q[head_q];
    head_value  = value_q[head_q];
    head_store  = is_store(head_op);
    head_branch = is_branch(head_op);
    head_taken  = |head_value;
    st_req      = busy_q[head_q] && ready_q[head_q] && head_store;
    head_ok     = busy_q[head_q] && ready_q[head_q] && (!head_store || st_ack);
    flush_now   = head_ok && ((head_branch && head_taken) || (head_op == OpJalr));
    alloc_ready = (count_q < DepthCnt) && !flush_now;
    alloc_fire  = alloc_valid && alloc_ready;
  end

  // Ring next state: writebacks (highest channel last so it wins), then alloc, commit, flush.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    value_d = value_q;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && busy_q[wb_idx[k]]) begin
        value_d[wb_idx[k]] = wb_val[k];
        ready_d[wb_idx[k]] = 1'b1;
      end
    end
    if (alloc_fire) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = ready_at_alloc(alloc_op);
      value_d[tail_q] = alloc_imm;
    end
    if (head_ok) begin
      busy_d[head_q] = 1'b0;
    end
    head_d  = head_q + idx_t'(head_ok);
    tail_d  = tail_q + idx_t'(alloc_fire);
    count_d = count_q + cnt_t'(alloc_fire) - cnt_t'(head_ok);
    if (flush_now) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = head_q + idx_t'(1);
      tail_d  = head_q + idx_t'(1);
      count_d = '0;
    end
  end

  always_comb begin
    commit_rd_d    = (head_branch || head_store) ? 5'd0 : rd_q[head_q];
    commit_value_d = head_value;
    if ((head_op == OpJal) || (head_op == OpJalr)) begin
      commit_value_d = head_pc + XLEN'(4);
    end else if (head_op == OpJalC) begin
      commit_value_d = head_pc + XLEN'(2);
    end else if (head_op == OpAuipc) begin
      commit_value_d = head_pc + head_imm;
    end else if (head_branch) begin
      commit_value_d = XLEN'(head_taken);
    end
    redirect_pc_d = (head_op == OpJalr) ? (head_value & ~XLEN'(1)) : (head_pc + head_imm);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      busy_q           <= '0;
      ready_q          <= '0;
      commit_valid_q   <= 1'b0;
      commit_rd_q      <= '0;
      commit_value_q   <= '0;
      commit_tag_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      busy_q           <= busy_d;
      ready_q          <= ready_d;
      commit_valid_q   <= head_ok;
      redirect_valid_q <= flush_now;
      if (head_ok) begin
        commit_rd_q    <= commit_rd_d;
        commit_value_q <= commit_value_d;
        commit_tag_q   <= head_q;
      end
      if (flush_now) begin
        redirect_pc_q <= redirect_pc_d;
      end
    end
  end

  // Payload storage needs no reset: busy/ready gate every use.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      op_q[tail_q]  <= alloc_op;
      rd_q[tail_q]  <= alloc_rd;
      pc_q[tail_q]  <= alloc_pc;
      imm_q[tail_q] <= alloc_imm;
    end
    value_q <= value_d;
  end

  idx_t            src_tag [2];
  logic [1:0]      src_rdy;
  logic [XLEN-1:0] src_val [2];

  assign src_tag[0] = src1_tag;
  assign src_tag[1] = src2_tag;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_rdy[s] = 1'b0;
      src_val[s] = '0;
      if (busy_q[src_tag[s]]) begin
        if (ready_q[src_tag[s]]) begin
          src_rdy[s] = 1'b1;
          src_val[s] = value_q[src_tag[s]];
        end
        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_valid[k] && (wb_idx[k] == src_tag[s])) begin
            src_rdy[s] = 1'b1;
            src_val[s] = wb_val[k];
          end
        end
      end
    end
  end

  assign src1_ready     = src_rdy[0];
  assign src2_ready     = src_rdy[1];
  assign src1_value     = src_val[0];
  assign src2_value     = src_val[1];
  assign alloc_tag      = tail_q;
  assign count          = count_q;
  assign commit_valid   = commit_valid_q;
  assign commit_rd      = commit_rd_q;
  assign commit_value   = commit_value_q;
  assign commit_tag     = commit_tag_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule
